dcr_reg_slave: RTL and testbench

DCR_REG_SLAVE -- requirements
Module: dcr_reg_slave

---
 rtl/dcr_reg_slave.sv | 202 ++++++++++++++++++++
 tb/tb_dcr_reg_slave.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcr_reg_slave.sv
// DCR register slave for a PPC405 master: CTRL/STATUS/SCRATCH/COUNT with programmable acknowledge delay.
// Optional interrupt output is built when DCR_SLAVE_IRQ_EN is defined; otherwise IRQ is tied low.
module dcr_reg_slave #(
  parameter logic [0:9]  BASE_ADDR = 10'h080,
  parameter int unsigned ACK_DLY   = 1
) (
  input  logic        CPMDCRCLK,
  input  logic        RSTDCRRESET,
  input  logic [0:9]  EXTDCRABUS,
  input  logic [0:31] EXTDCRDBUSOUT,
  input  logic        EXTDCRREAD,
  input  logic        EXTDCRWRITE,
  output logic        EXTDCRACK,
  output logic [0:31] EXTDCRDBUSIN,
  input  logic        EVENT,
  output logic [0:31] CTRLOUT,
  output logic        IRQ
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned DW    = 32;
  localparam logic [CNT_W-1:0] WAIT_LAST = (ACK_DLY == 0) ? '0 : CNT_W'(ACK_DLY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0] wait_cnt;
  logic             hit_c;
  logic             access_c;

  // transfer operands latched on the hit edge
  logic [1:0]       sel_q;
  logic [0:DW-1]    wdata_q;
  logic             rd_q;
  logic             wr_q;

  logic [1:0]       sel_c;
  logic [0:DW-1]    wdata_c;
  logic             rd_c;
  logic             wr_c;

  logic [0:DW-1]    ctrl_q;
  logic [0:DW-1]    scratch_q;
  logic [0:DW-1]    count_q;
  logic             evt_q;
  logic             err_q;
  logic [0:DW-1]    rdata_q;
  logic             ack_q;

  logic             ctrl_we_c;
  logic             scratch_we_c;
  logic             status_we_c;
  logic             count_clr_c;
  logic             err_set_c;
  logic [0:DW-1]    reg_rd_c;

  assign hit_c = (EXTDCRABUS[0:7] == BASE_ADDR[0:7]) && (EXTDCRREAD || EXTDCRWRITE);

  // state register
  always_ff @(posedge CPMDCRCLK) begin
    if (RSTDCRRESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next state; access_c marks the edge that enters ACK
  always_comb begin
    next_state = state;
    access_c   = 1'b0;
    case (state)
      IDLE: begin
        if (hit_c) begin
          if (ACK_DLY == 0) begin
            next_state = ACK;
            access_c   = 1'b1;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          next_state = ACK;
          access_c   = 1'b1;
        end
      end
      ACK:  next_state = HOLD;
      HOLD: begin
        if (!EXTDCRREAD && !EXTDCRWRITE) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // with zero delay the access happens on the hit edge, so use the live bus
  always_comb begin
    sel_c   = sel_q;
    wdata_c = wdata_q;
    rd_c    = rd_q;
    wr_c    = wr_q;
    if (state == IDLE) begin
      sel_c   = EXTDCRABUS[8:9];
      wdata_c = EXTDCRDBUSOUT;
      rd_c    = EXTDCRREAD;
      wr_c    = EXTDCRWRITE;
    end
  end

  always_ff @(posedge CPMDCRCLK) begin
    if (RSTDCRRESET) begin
      wait_cnt <= '0;
      sel_q    <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
      if (state == IDLE && hit_c) begin
        sel_q   <= EXTDCRABUS[8:9];
        wdata_q <= EXTDCRDBUSOUT;
        rd_q    <= EXTDCRREAD;
        wr_q    <= EXTDCRWRITE;
      end
      ack_q <= (next_state == ACK) || (next_state == HOLD);
    end
  end

  always_comb begin
    ctrl_we_c    = 1'b0;
    scratch_we_c = 1'b0;
    status_we_c  = 1'b0;
    count_clr_c  = 1'b0;
    err_set_c    = access_c && rd_c && wr_c;
    if (access_c && wr_c && !rd_c) begin
      case (sel_c)
        2'd0:    ctrl_we_c    = 1'b1;
        2'd1:    status_we_c  = 1'b1;
        2'd2:    scratch_we_c = 1'b1;
        default: count_clr_c  = 1'b1;
      endcase
    end
  end

  always_comb begin
    reg_rd_c = '0;
    case (sel_c)
      2'd0:    reg_rd_c = ctrl_q;
      2'd1:    reg_rd_c = {30'b0, err_q, evt_q};
      2'd2:    reg_rd_c = scratch_q;
      default: reg_rd_c = count_q;
    endcase
  end

  // register file; event set beats write-1-to-clear, count write beats increment
  always_ff @(posedge CPMDCRCLK) begin
    if (RSTDCRRESET) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      evt_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (ctrl_we_c)    ctrl_q    <= wdata_c;
      if (scratch_we_c) scratch_q <= wdata_c;
      if (access_c)     rdata_q   <= (rd_c && !wr_c) ? reg_rd_c : '0;
      evt_q   <= EVENT | (evt_q & ~(status_we_c & wdata_c[31]));
      err_q   <= err_set_c | (err_q & ~(status_we_c & wdata_c[30]));
      count_q <= count_clr_c ? '0 : count_q + DW'(EVENT);
    end
  end

`ifdef DCR_SLAVE_IRQ_EN
  logic irq_q;

  always_ff @(posedge CPMDCRCLK) begin
    if (RSTDCRRESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ctrl_q[31] & (evt_q | err_q);
    end
  end

  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

  assign EXTDCRACK    = ack_q;
  assign EXTDCRDBUSIN = ack_q ? rdata_q : EXTDCRDBUSOUT;
  assign CTRLOUT      = ctrl_q;

endmodule

// File: tb/tb_dcr_reg_slave.sv
// Testbench for dcr_reg_slave: directed scenarios plus randomized transfers checked against a transaction-level model.
module tb_dcr_reg_slave;

  localparam logic [9:0] BASE    = 10'h080;
  localparam int         ACK_DLY = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:9]  abus = '0;
  logic [0:31] dbus_out = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        ev = 1'b0;
  logic        ack;
  logic [0:31] dbus_in;
  logic [0:31] ctrl_out;
  logic        irq;

  dcr_reg_slave #(.BASE_ADDR(BASE), .ACK_DLY(ACK_DLY)) dut (
    .CPMDCRCLK(clk), .RSTDCRRESET(rst), .EXTDCRABUS(abus), .EXTDCRDBUSOUT(dbus_out),
    .EXTDCRREAD(rd), .EXTDCRWRITE(wr), .EXTDCRACK(ack), .EXTDCRDBUSIN(dbus_in),
    .EVENT(ev), .CTRLOUT(ctrl_out), .IRQ(irq)
  );

  always #5 clk = ~clk;

  // model: m_age counts edges since the hit (-1 = no transfer in progress)
  int          m_age = -1;
  logic [1:0]  m_sel = '0;
  logic [31:0] m_wd = '0;
  logic        m_rd = 1'b0, m_wr = 1'b0;
  logic [31:0] m_ctrl = '0, m_scr = '0, m_cnt = '0, m_rdata = '0;
  logic        m_evt = 1'b0, m_err = 1'b0, m_irq = 1'b0;
  logic [9:0]  m_a;
  logic        m_acc, m_clr, m_eset, m_irq_nx;
  logic [1:0]  m_w1c;

  function automatic logic [31:0] m_read(input logic [1:0] s);
    case (s)
      2'd0:    return m_ctrl;
      2'd1:    return {30'b0, m_err, m_evt};
      2'd2:    return m_scr;
      default: return m_cnt;
    endcase
  endfunction

  always @(posedge clk) begin
    m_a = abus;
    if (rst) begin
      m_age = -1; m_ctrl = '0; m_scr = '0; m_cnt = '0;
      m_evt = 1'b0; m_err = 1'b0; m_irq = 1'b0; m_rdata = '0;
    end else begin
      m_acc = 1'b0; m_clr = 1'b0; m_eset = 1'b0; m_w1c = '0;
      if (m_age < 0) begin
        if (m_a[9:2] == BASE[9:2] && (rd || wr)) begin
          m_age = 0; m_sel = m_a[1:0]; m_wd = dbus_out; m_rd = rd; m_wr = wr;
          m_acc = (ACK_DLY == 0);
        end
      end else if (m_age < ACK_DLY) begin
        m_age++;
        m_acc = (m_age == ACK_DLY);
      end else if (m_age == ACK_DLY) begin
        m_age++;
      end else if (!rd && !wr) begin
        m_age = -1;
      end
`ifdef DCR_SLAVE_IRQ_EN
      m_irq_nx = m_ctrl[0] & (m_evt | m_err);
`else
      m_irq_nx = 1'b0;
`endif
      if (m_acc) begin
        if (m_rd && m_wr) begin
          m_rdata = '0; m_eset = 1'b1;
        end else if (m_rd) begin
          m_rdata = m_read(m_sel);
        end else begin
          m_rdata = '0;
          case (m_sel)
            2'd0:    m_ctrl = m_wd;
            2'd1:    m_w1c = m_wd[1:0];
            2'd2:    m_scr = m_wd;
            default: m_clr = 1'b1;
          endcase
        end
      end
      m_evt = ev | (m_evt & ~m_w1c[0]);
      m_err = m_eset | (m_err & ~m_w1c[1]);
      m_cnt = m_clr ? 32'd0 : m_cnt + 32'(ev);
      m_irq = m_irq_nx;
    end
  end

  int vec = 0;
  int err = 0;
  bit check_en = 1'b0;
  bit ev_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // one cycle: wait for the falling edge, compare against the model, then refresh EVENT
  task automatic cyc();
    @(negedge clk);
    if (check_en) begin
      chk("ack", 32'(ack), 32'(m_age >= ACK_DLY));
      if (m_age < ACK_DLY) chk("bypass", dbus_in, dbus_out);
      else if (m_rd) chk("rdata", dbus_in, m_rdata);
      chk("ctrlout", ctrl_out, m_ctrl);
      chk("irq", 32'(irq), 32'(m_irq));
    end
    ev = ev_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic xfer(input bit r, input bit w, input logic [9:0] a, input logic [31:0] d,
                      input bit ev_at_ack, input int hold, output logic [31:0] rdat, output int lat);
    abus = a; dbus_out = d; rd = r; wr = w;
    lat = 0;
    rdat = '0;
    if (ev_at_ack && ACK_DLY == 0) ev = 1'b1;
    forever begin
      cyc();
      lat++;
      if (ack) begin
        rdat = dbus_in;
        break;
      end
      if (ev_at_ack && lat == ACK_DLY) ev = 1'b1;
      if (lat > 30) begin
        chk("ack_timeout", 32'(ack), 32'd1);
        break;
      end
    end
    repeat (hold) cyc();
    rd = 1'b0; wr = 1'b0; dbus_out = $urandom;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (!ack) break;
      if (i == 9) chk("ack_release_timeout", 32'(ack), 32'd0);
    end
  endtask

  logic [31:0] rv;
  int          lat;
  int          acks;
  logic [9:0]  ma;
  int          kind;

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    check_en = 1'b1;
    cyc();
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_ctrl", ctrl_out, 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);

    // scratch write/readback and acknowledge latency
    xfer(1'b0, 1'b1, BASE + 10'd2, 32'hA5A5_0001, 1'b0, 0, rv, lat);
    chk("scratch_ack_latency", 32'(lat), 32'd2);
    xfer(1'b1, 1'b0, BASE + 10'd2, 32'h0, 1'b0, 1, rv, lat);
    chk("scratch_readback", rv, 32'hA5A5_0001);
    xfer(1'b0, 1'b1, BASE, 32'h1234_ABCD, 1'b0, 0, rv, lat);
    cyc();
    chk("ctrlout_value", ctrl_out, 32'h1234_ABCD);

    // miss: no acknowledge, bus bypass
    abus = 10'h3FF; dbus_out = 32'h1234_5678; rd = 1'b1;
    acks = 0;
    repeat (20) begin
      cyc();
      if (ack) acks++;
    end
    chk("miss_ack_count", 32'(acks), 32'd0);
    chk("miss_bypass", dbus_in, 32'h1234_5678);
    rd = 1'b0;
    cyc();

    // counter
    xfer(1'b0, 1'b1, BASE + 10'd3, 32'h0, 1'b0, 0, rv, lat);
    repeat (5) begin
      ev = 1'b1;
      cyc();
    end
    xfer(1'b1, 1'b0, BASE + 10'd3, 32'h0, 1'b0, 0, rv, lat);
    chk("count_five", rv, 32'd5);
    xfer(1'b0, 1'b1, BASE + 10'd3, 32'hFFFF_FFFF, 1'b0, 0, rv, lat);
    xfer(1'b1, 1'b0, BASE + 10'd3, 32'h0, 1'b0, 0, rv, lat);
    chk("count_cleared", rv, 32'd0);

    // status: set beats clear, then a plain clear
    ev = 1'b1;
    cyc();
    xfer(1'b0, 1'b1, BASE + 10'd1, 32'h0000_0001, 1'b1, 0, rv, lat);
    xfer(1'b1, 1'b0, BASE + 10'd1, 32'h0, 1'b0, 0, rv, lat);
    chk("status_set_wins", rv, 32'h0000_0001);
    xfer(1'b0, 1'b1, BASE + 10'd1, 32'h0000_0001, 1'b0, 0, rv, lat);
    xfer(1'b1, 1'b0, BASE + 10'd1, 32'h0, 1'b0, 0, rv, lat);
    chk("status_cleared", rv, 32'h0);

    // simultaneous read and write
    xfer(1'b0, 1'b1, BASE, 32'h0000_0001, 1'b0, 0, rv, lat);
    xfer(1'b1, 1'b1, BASE, 32'hFFFF_FFFF, 1'b0, 0, rv, lat);
    chk("rdwr_rdata", rv, 32'h0);
    chk("rdwr_ctrl_kept", ctrl_out, 32'h0000_0001);
`ifdef DCR_SLAVE_IRQ_EN
    chk("rdwr_irq", 32'(irq), 32'd1);
`else
    chk("rdwr_irq", 32'(irq), 32'd0);
`endif
    xfer(1'b1, 1'b0, BASE + 10'd1, 32'h0, 1'b0, 0, rv, lat);
    chk("rdwr_status_err", rv, 32'h0000_0002);
    xfer(1'b0, 1'b1, BASE + 10'd1, 32'h0000_0003, 1'b0, 0, rv, lat);

    // reset during WAIT aborts, held request is then served
    abus = BASE; dbus_out = 32'hDEAD_BEEF; wr = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_ctrl", ctrl_out, 32'd0);
    xfer(1'b0, 1'b1, BASE, 32'hDEAD_BEEF, 1'b0, 0, rv, lat);
    chk("retry_latency", 32'(lat), 32'(ACK_DLY + 1));
    chk("retry_ctrl", ctrl_out, 32'hDEAD_BEEF);

    // randomized traffic with random events
    ev_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        repeat ($urandom_range(1, 3)) cyc();
      end else if (kind == 2) begin
        ma = 10'($urandom);
        if (ma[9:2] == BASE[9:2]) ma[9] = ~ma[9];
        abus = ma; dbus_out = $urandom; rd = $urandom_range(0, 1) == 1; wr = !rd;
        repeat (3) cyc();
        rd = 1'b0; wr = 1'b0;
        cyc();
      end else begin
        kind = $urandom_range(0, 4);
        xfer(kind != 1, kind <= 1, {BASE[9:2], 2'($urandom)}, $urandom,
             1'b0, $urandom_range(0, 2), rv, lat);
      end
    end
    ev_rand = 1'b0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
